// File: rtl/twi_init_sequencer.sv
// ---------------------------------------------------------------------------------------------
// twi_init_sequencer
//
// Walks a small table of initialisation entries and turns them into write commands for a TWI
// (I2C) master. Each 18-bit entry is {opcode[1:0], addr_byte[7:0], data_byte[7:0]}:
//   00 END    - stop, pulse oDone
//   01 WRITE  - issue one command (addr/RW byte + data byte), retry up to RETRY_MAX on NACK
//   10 DELAY  - wait data_byte * DELAY_UNIT clock cycles
//   11        - illegal entry, flagged as an error
//
// Ports
//   iPlbClk, iPlbResetN  : clock (rising edge) and asynchronous active-low reset
//   iStart               : one-cycle start pulse, honoured only while idle
//   oBusy / oDone        : sequence running / one-cycle completion pulse
//   oError / oErrIndex   : sticky failure flag and index of the failing entry
//   oTblAddr / iTblData  : table read port, data valid one cycle after the address
//   oCmdValid/iCmdReady  : command handshake towards the TWI master
//   oCmdAddr / oCmdData  : command address/RW byte and data byte
//   iRspValid / iRspAck  : end-of-transaction pulse and its ACK status
// ---------------------------------------------------------------------------------------------
module twi_init_sequencer #(
  parameter int unsigned TBL_ADDR_WIDTH = 6,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned DELAY_UNIT     = 1000
) (
  input  logic                      iPlbClk,
  input  logic                      iPlbResetN,
  input  logic                      iStart,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oError,
  output logic [TBL_ADDR_WIDTH-1:0] oErrIndex,
  output logic [TBL_ADDR_WIDTH-1:0] oTblAddr,
  input  logic [17:0]               iTblData,
  output logic                      oCmdValid,
  input  logic                      iCmdReady,
  output logic [7:0]                oCmdAddr,
  output logic [7:0]                oCmdData,
  input  logic                      iRspValid,
  input  logic                      iRspAck
);

  // Counter must hold 255 * DELAY_UNIT; attempt counter must hold RETRY_MAX.
  localparam int unsigned CntW = (DELAY_UNIT > 1) ? $clog2(255 * DELAY_UNIT + 1) : 8;
  localparam int unsigned AttW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [1:0] OpEnd   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpDelay = 2'b10;
  localparam logic [1:0] OpBad   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitRsp,
    StDelay,
    StFinish
  } state_e;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [TBL_ADDR_WIDTH-1:0] r_index;
  logic [TBL_ADDR_WIDTH-1:0] r_err_index;
  logic [AttW-1:0]           r_attempts;
  logic [CntW-1:0]           r_cnt;
  logic [7:0]                r_cmd_addr;
  logic [7:0]                r_cmd_data;
  logic                      r_error;

  logic [1:0]                w_opcode;
  logic [CntW-1:0]           w_delay_load;
  logic                      w_rsp_ack;
  logic                      w_can_retry;
  logic                      w_delay_done;
  logic                      w_advance;
  logic                      w_last;
  state_e                    w_adv_state;

  assign w_opcode     = iTblData[17:16];
  assign w_delay_load = CntW'(iTblData[7:0]) * CntW'(DELAY_UNIT);
  assign w_rsp_ack    = (r_state == StWaitRsp) && iRspValid && iRspAck;
  assign w_can_retry  = (r_attempts < AttW'(RETRY_MAX));
  // Last decrement (or an already-zero load) ends the wait, so a delay of N ticks spends
  // exactly N*DELAY_UNIT cycles in DELAY and a zero delay spends a single cycle there.
  assign w_delay_done = (r_state == StDelay) && (r_cnt <= CntW'(1));
  assign w_advance    = w_rsp_ack || w_delay_done;
  // The top table index ends the sequence instead of wrapping back to entry 0.
  assign w_last       = &r_index;
  assign w_adv_state  = w_last ? StFinish : StFetch;

  // State register
  always_ff @(posedge iPlbClk or negedge iPlbResetN) begin
    if (!iPlbResetN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (iStart) w_state_nxt = StFetch;
      end
      StFetch: begin
        w_state_nxt = StDecode;
      end
      StDecode: begin
        unique case (w_opcode)
          OpEnd:   w_state_nxt = StFinish;
          OpWrite: w_state_nxt = StIssue;
          OpDelay: w_state_nxt = StDelay;
          OpBad:   w_state_nxt = StFinish;
        endcase
      end
      StIssue: begin
        if (iCmdReady) w_state_nxt = StWaitRsp;
      end
      StWaitRsp: begin
        if (iRspValid) begin
          if (iRspAck)          w_state_nxt = w_adv_state;
          else if (w_can_retry) w_state_nxt = StIssue;
          else                  w_state_nxt = StFinish;
        end
      end
      StDelay: begin
        if (w_delay_done) w_state_nxt = w_adv_state;
      end
      StFinish: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Datapath registers: index, retry count, delay counter, command bytes, error capture
  always_ff @(posedge iPlbClk or negedge iPlbResetN) begin
    if (!iPlbResetN) begin
      r_index     <= '0;
      r_err_index <= '0;
      r_attempts  <= '0;
      r_cnt       <= '0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (iStart) begin
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_index     <= '0;
            r_attempts  <= '0;
            r_cnt       <= '0;
          end
        end
        StDecode: begin
          if (w_opcode == OpWrite) begin
            r_cmd_addr <= iTblData[15:8];
            r_cmd_data <= iTblData[7:0];
          end
          if (w_opcode == OpDelay) begin
            r_cnt <= w_delay_load;
          end
          if (w_opcode == OpBad) begin
            r_error     <= 1'b1;
            r_err_index <= r_index;
          end
        end
        StWaitRsp: begin
          if (iRspValid) begin
            if (iRspAck) begin
              r_attempts <= '0;
            end else if (w_can_retry) begin
              r_attempts <= r_attempts + AttW'(1);
            end else begin
              r_error     <= 1'b1;
              r_err_index <= r_index;
            end
          end
        end
        StDelay: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
        end
        default: ;
      endcase

      if (w_advance && !w_last) begin
        r_index <= r_index + TBL_ADDR_WIDTH'(1);
      end
    end
  end

  // Outputs: handshake and status decoded from state so reset drops them immediately
  always_comb begin
    oBusy     = (r_state != StIdle);
    oDone     = (r_state == StFinish);
    oCmdValid = (r_state == StIssue);
    oTblAddr  = r_index;
    oCmdAddr  = r_cmd_addr;
    oCmdData  = r_cmd_data;
    oError    = r_error;
    oErrIndex = r_err_index;
  end

endmodule

// File: tb/tb_twi_init_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_twi_init_sequencer
//
// Directed bench for twi_init_sequencer (TBL_ADDR_WIDTH=2, RETRY_MAX=3, DELAY_UNIT=4).
// The stimulus process loads a table, pushes the expected commands and completion status into
// queues and pulses iStart. A responder model plays the TWI master; a monitor pops and compares
// every presented command and every oDone pulse.
// ---------------------------------------------------------------------------------------------
module tb_twi_init_sequencer;

  localparam int unsigned Aw = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          error;
  logic [Aw-1:0] err_index;
  logic [Aw-1:0] tbl_addr;
  logic [17:0]   tbl_rd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_addr;
  logic [7:0]    cmd_data;
  logic          rsp_valid;
  logic          rsp_ack;

  twi_init_sequencer #(
    .TBL_ADDR_WIDTH (Aw),
    .RETRY_MAX      (3),
    .DELAY_UNIT     (4)
  ) dut (
    .iPlbClk    (clk),
    .iPlbResetN (rst_n),
    .iStart     (start),
    .oBusy      (busy),
    .oDone      (done),
    .oError     (error),
    .oErrIndex  (err_index),
    .oTblAddr   (tbl_addr),
    .iTblData   (tbl_rd),
    .oCmdValid  (cmd_valid),
    .iCmdReady  (cmd_ready),
    .oCmdAddr   (cmd_addr),
    .oCmdData   (cmd_data),
    .iRspValid  (rsp_valid),
    .iRspAck    (rsp_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read table: data follows the address by one cycle.
  logic [17:0] tbl [4];
  always @(posedge clk) tbl_rd <= tbl[tbl_addr];

  int          checks;
  int          errors;
  int          done_cnt;
  int          acc_cnt;
  logic [15:0] exp_cmd_q [$];
  logic [2:0]  exp_done_q [$];

  // Responder knobs
  int          stall_cycles;
  int          rsp_lat;
  bit          nack_en;
  logic [7:0]  nack_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [17:0] e0, input logic [17:0] e1,
                      input logic [17:0] e2, input logic [17:0] e3);
    tbl[0] = e0;
    tbl[1] = e1;
    tbl[2] = e2;
    tbl[3] = e3;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s_timeout: got no oDone within %0d cycles, required one", name, n);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (4) tick();
    chk({name, "_cmds_left"}, exp_cmd_q.size(), 0);
    chk({name, "_done_left"}, exp_done_q.size(), 0);
  endtask

  // TWI master model
  initial begin
    logic [7:0] seen;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    forever begin
      tick();
      rsp_valid = 1'b0;
      rsp_ack   = 1'b0;
      if (cmd_valid) begin
        repeat (stall_cycles) tick();
        cmd_ready = 1'b1;
        seen      = cmd_data;
        tick();
        cmd_ready = 1'b0;
        repeat (rsp_lat) tick();
        rsp_valid = 1'b1;
        rsp_ack   = !(nack_en && seen == nack_data);
      end
    end
  end

  // Monitor / scoreboard
  logic [15:0] mon_cmd;
  logic [2:0]  mon_done;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %02h/%02h, required no command", cmd_addr, cmd_data);
        end else begin
          mon_cmd = exp_cmd_q[0];
          chk("cmd_addr", cmd_addr, mon_cmd[15:8]);
          chk("cmd_data", cmd_data, mon_cmd[7:0]);
          if (cmd_ready) begin
            mon_cmd = exp_cmd_q.pop_front();
            acc_cnt++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got oDone, required none");
        end else begin
          mon_done = exp_done_q.pop_front();
          chk("done_error", error, mon_done[2]);
          chk("done_err_index", err_index, mon_done[1:0]);
          chk("done_busy", busy, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    checks       = 0;
    errors       = 0;
    done_cnt     = 0;
    acc_cnt      = 0;
    stall_cycles = 0;
    rsp_lat      = 2;
    nack_en      = 1'b0;
    nack_data    = 8'h00;
    start        = 1'b0;
    rst_n        = 1'b0;
    load(18'h0, 18'h0, 18'h0, 18'h0);

    // Reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_cmd_bytes", {cmd_addr, cmd_data}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Two acknowledged writes then END
    load({2'b01, 16'hBEEF}, {2'b01, 16'hBE12}, {2'b00, 16'h0}, {2'b00, 16'h0});
    exp_cmd_q.push_back(16'hBEEF);
    exp_cmd_q.push_back(16'hBE12);
    exp_done_q.push_back(3'b0_00);
    start_pulse();
    chk("t1_busy", busy, 1);
    n = 0;
    while (!cmd_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t1_first_cmd_latency", n, 2);
    wait_done("t1");
    check_drained("t1");
    chk("t1_error", error, 0);

    // Entry 1 NACKs on every attempt: 1 + RETRY_MAX commands, entry 2 never issued
    load({2'b01, 16'hA001}, {2'b01, 16'hA002}, {2'b01, 16'hA003}, {2'b00, 16'h0});
    nack_en   = 1'b1;
    nack_data = 8'h02;
    exp_cmd_q.push_back(16'hA001);
    repeat (4) exp_cmd_q.push_back(16'hA002);
    exp_done_q.push_back(3'b1_01);
    start_pulse();
    wait_done("t2");
    check_drained("t2");
    nack_en = 1'b0;
    repeat (5) tick();
    chk("t2_error_sticky", error, 1);
    chk("t2_err_index_sticky", err_index, 1);

    // Illegal opcode at index 2; the start also clears the old error
    load({2'b01, 16'h5566}, {2'b01, 16'h5567}, {2'b11, 16'h0}, {2'b00, 16'h0});
    exp_cmd_q.push_back(16'h5566);
    exp_cmd_q.push_back(16'h5567);
    exp_done_q.push_back(3'b1_10);
    start_pulse();
    chk("t3_error_cleared", error, 0);
    wait_done("t3");
    check_drained("t3");

    // DELAY 3 (x4 = 12 cycles), DELAY 0, then a write
    load({2'b10, 16'h0003}, {2'b10, 16'h0000}, {2'b01, 16'hA05A}, {2'b00, 16'h0});
    exp_cmd_q.push_back(16'hA05A);
    exp_done_q.push_back(3'b0_00);
    start_pulse();
    n = 0;
    while (!cmd_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t4_delay_latency", n, 19);
    wait_done("t4");
    check_drained("t4");
    chk("t4_error", error, 0);

    // Ready held low for 20 cycles: monitor re-checks the bytes every stalled cycle
    load({2'b01, 16'hC33C}, {2'b00, 16'h0}, {2'b00, 16'h0}, {2'b00, 16'h0});
    stall_cycles = 20;
    base = acc_cnt;
    exp_cmd_q.push_back(16'hC33C);
    exp_done_q.push_back(3'b0_00);
    start_pulse();
    wait_done("t5");
    check_drained("t5");
    chk("t5_accepts", acc_cnt - base, 1);
    stall_cycles = 0;

    // Reset while waiting for a response, then restart from index 0
    load({2'b01, 16'h1122}, {2'b01, 16'h3344}, {2'b00, 16'h0}, {2'b00, 16'h0});
    rsp_lat = 12;
    base = acc_cnt;
    exp_cmd_q.push_back(16'h1122);
    start_pulse();
    n = 0;
    while (acc_cnt == base && n < 100) begin
      tick();
      n++;
    end
    chk("t6_first_accept", acc_cnt - base, 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd_valid", cmd_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_error", error, 0);
    chk("t6_rst_tbl_addr", tbl_addr, 0);
    chk("t6_rst_err_index", err_index, 0);
    chk("t6_rst_cmd_bytes", {cmd_addr, cmd_data}, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t6_no_resume", busy, 0);
    rsp_lat = 2;
    exp_cmd_q.push_back(16'h1122);
    exp_cmd_q.push_back(16'h3344);
    exp_done_q.push_back(3'b0_00);
    start_pulse();
    wait_done("t6");
    check_drained("t6");

    // No END entry: all four entries run, no wrap; a start while busy is ignored
    load({2'b01, 16'h1001}, {2'b01, 16'h1002}, {2'b01, 16'h1003}, {2'b01, 16'h1004});
    base = acc_cnt;
    for (int i = 1; i <= 4; i++) exp_cmd_q.push_back({8'h10, 8'(i)});
    exp_done_q.push_back(3'b0_00);
    start_pulse();
    n = 0;
    while (acc_cnt - base < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("t7_busy_before_restart", busy, 1);
    start_pulse();
    wait_done("t7");
    repeat (20) tick();
    check_drained("t7");
    chk("t7_accepts", acc_cnt - base, 4);
    chk("t7_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
